pipeline_stall_ctrl: RTL and testbench

//  Central sequencer for the 6-bit stall bus consumed by pc_reg and every inter-stage buffer (if/id, id/ex, ex/mem, mem/wb).

---
 rtl/pipeline_stall_ctrl_pkg.sv | 36 +++
 rtl/pipeline_stall_ctrl_ex_hold_counter.sv | 36 +++
 rtl/pipeline_stall_ctrl.sv | 103 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared stall-bus encodings, FSM state codes and default sizes for the stall controller.
// Bus bit order: 0=pc, 1=if, 2=id, 3=ex, 4=mem, 5=wb.
package pipeline_stall_ctrl_pkg;

  localparam int DEF_STALL_WIDTH    = 6;
  localparam int DEF_HOLD_CNT_WIDTH = 6;
  localparam int DEF_WDOG_LIMIT     = 1024;

  localparam logic [DEF_STALL_WIDTH-1:0] STALL_NONE = 6'b000000;
  localparam logic [DEF_STALL_WIDTH-1:0] STALL_IF   = 6'b000011;
  localparam logic [DEF_STALL_WIDTH-1:0] STALL_ID   = 6'b000111;
  localparam logic [DEF_STALL_WIDTH-1:0] STALL_EX   = 6'b001111;
  localparam logic [DEF_STALL_WIDTH-1:0] STALL_MEM  = 6'b011111;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Each request freezes its own stage and everything upstream; OR-ing lets the deepest stage win.
  function automatic logic [DEF_STALL_WIDTH-1:0] merge_stall(
    input logic if_req,
    input logic id_req,
    input logic ex_req,
    input logic mem_req
  );
    logic [DEF_STALL_WIDTH-1:0] m;
    m = STALL_NONE;
    if (if_req)  m = m | STALL_IF;
    if (id_req)  m = m | STALL_ID;
    if (ex_req)  m = m | STALL_EX;
    if (mem_req) m = m | STALL_MEM;
    return m;
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_ex_hold_counter.sv
// Down-counter timing EX multi-cycle holds: loads on an accepted start, decrements while MEM
// is not stalling, and drives the EX stall request for the start cycle and while nonzero.
module pipeline_stall_ctrl_ex_hold_counter
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int HOLD_CNT_WIDTH = DEF_HOLD_CNT_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      start,
  input  logic [HOLD_CNT_WIDTH-1:0] cycles,
  input  logic                      freeze,
  output logic                      busy,
  output logic                      ex_req
);

  logic [HOLD_CNT_WIDTH-1:0] cnt;
  logic                      load;

  // A start during an active hold or with zero cycles is dropped.
  assign load   = start && (cycles != '0) && (cnt == '0);
  assign busy   = (cnt != '0);
  assign ex_req = load || busy;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= cycles;
    end else if (busy && !freeze) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Merges per-stage stall requests into the stall bus, sequences a one-cycle flush on exception,
// and runs a sticky watchdog on consecutive stalled cycles. stall/flush/new_pc are zero-latency.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int STALL_WIDTH    = DEF_STALL_WIDTH,
  parameter int HOLD_CNT_WIDTH = DEF_HOLD_CNT_WIDTH,
  parameter int WDOG_LIMIT     = DEF_WDOG_LIMIT
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      if_stall_req,
  input  logic                      id_stall_req,
  input  logic                      mem_stall_req,
  input  logic                      ex_hold_start,
  input  logic [HOLD_CNT_WIDTH-1:0] ex_hold_cycles,
  input  logic                      flush_req,
  input  logic [31:0]               flush_target_pc,
  output logic [STALL_WIDTH-1:0]    stall,
  output logic                      flush,
  output logic [31:0]               new_pc,
  output logic                      ex_hold_busy,
  output logic                      wdog_timeout
);

  localparam int                WCNT_W   = $clog2(WDOG_LIMIT);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(WDOG_LIMIT - 1);

  state_t            state;
  logic              run;
  logic              flush_now;
  logic              pass_reqs;
  logic              mem_active;
  logic              ex_req;
  logic              stalling;
  logic [31:0]       new_pc_q;
  logic [WCNT_W-1:0] wcnt;

  assign run        = (state == ST_RUN);
  assign flush_now  = run && flush_req;
  // The FLUSH cycle passes no stalls so the handler fetch can proceed.
  assign pass_reqs  = run && !flush_req;
  assign mem_active = pass_reqs && mem_stall_req;

  pipeline_stall_ctrl_ex_hold_counter #(
    .HOLD_CNT_WIDTH(HOLD_CNT_WIDTH)
  ) u_ex_hold (
    .clock  (clock),
    .reset  (reset),
    .clear  (flush_now),
    .start  (run && ex_hold_start),
    .cycles (ex_hold_cycles),
    .freeze (mem_active),
    .busy   (ex_hold_busy),
    .ex_req (ex_req)
  );

  always_comb begin
    stall = '0;
    if (pass_reqs) begin
      stall = STALL_WIDTH'(merge_stall(if_stall_req, id_stall_req, ex_req, mem_stall_req));
    end
  end

  assign stalling = (stall != '0);
  assign flush    = flush_now;
  assign new_pc   = flush_now ? flush_target_pc : new_pc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= ST_RUN;
      new_pc_q <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush_req) begin
            state    <= ST_FLUSH;
            new_pc_q <= flush_target_pc;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  // wcnt equals the number of preceding consecutive stalled cycles, saturating at LIMIT-1.
  always_ff @(posedge clock) begin
    if (reset) begin
      wcnt         <= '0;
      wdog_timeout <= 1'b0;
    end else begin
      if (flush_now || !stalling) begin
        wcnt <= '0;
      end else if (wcnt < WCNT_MAX) begin
        wcnt <= wcnt + 1'b1;
      end
      if (stalling && (wcnt >= WCNT_MAX)) begin
        wdog_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed, table-driven bench for pipeline_stall_ctrl plus hand sequences for watchdog and reset.
module tb_pipeline_stall_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        if_stall_req, id_stall_req, mem_stall_req, ex_hold_start, flush_req;
  logic [5:0]  ex_hold_cycles;
  logic [31:0] flush_target_pc;
  logic [5:0]  stall;
  logic        flush, ex_hold_busy, wdog_timeout;
  logic [31:0] new_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_stall_ctrl dut (
    .clock           (clock),
    .reset           (reset),
    .if_stall_req    (if_stall_req),
    .id_stall_req    (id_stall_req),
    .mem_stall_req   (mem_stall_req),
    .ex_hold_start   (ex_hold_start),
    .ex_hold_cycles  (ex_hold_cycles),
    .flush_req       (flush_req),
    .flush_target_pc (flush_target_pc),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .ex_hold_busy    (ex_hold_busy),
    .wdog_timeout    (wdog_timeout)
  );

  typedef struct {
    logic        ifr, idr, memr, exs;
    logic [5:0]  k;
    logic        fr;
    logic [31:0] pc;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic ifr, idr, memr, exs, input logic [5:0] k,
                              input logic fr, input logic [31:0] pc, input logic [5:0] e_stall,
                              input logic e_flush, input logic [31:0] e_pc, input logic e_busy);
    vec_t v;
    v.ifr = ifr; v.idr = idr; v.memr = memr; v.exs = exs; v.k = k; v.fr = fr; v.pc = pc;
    v.e_stall = e_stall; v.e_flush = e_flush; v.e_pc = e_pc; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic ifr, idr, memr, exs, input logic [5:0] k,
                       input logic fr, input logic [31:0] pc);
    if_stall_req = ifr; id_stall_req = idr; mem_stall_req = memr;
    ex_hold_start = exs; ex_hold_cycles = k; flush_req = fr; flush_target_pc = pc;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    localparam logic [31:0] H = 32'hBFC00380;
    drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
    reset = 1'b1;
    next_cycle();
    next_cycle();
    check("reset_stall", {26'b0, stall}, 32'h0);
    check("reset_flush", {31'b0, flush}, 32'h0);
    check("reset_new_pc", new_pc, 32'h0);
    check("reset_busy", {31'b0, ex_hold_busy}, 32'h0);
    check("reset_wdog", {31'b0, wdog_timeout}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check("idle_stall", {26'b0, stall}, 32'h0);
      check("idle_flush", {31'b0, flush}, 32'h0);
    end

    //             if id mem exs k  fr pc            stall  fl npc        busy
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,           6'h03, 0, 0,         0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,           6'h07, 0, 0,         0));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,           6'h1F, 0, 0,         0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0,           6'h07, 0, 0,         0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,           6'h1F, 0, 0,         0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0,           6'h1F, 0, 0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h00, 0, 0,         0));
    // hold of 3 extra cycles: 4 stalled cycles total
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,           6'h0F, 0, 0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h00, 0, 0,         0));
    // mem stall in hold cycle 2 freezes the count: one extra cycle
    vecs.push_back(mk(0, 0, 0, 1, 3, 0, 0,           6'h0F, 0, 0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0,           6'h1F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h00, 0, 0,         0));
    // K=0 ignored; restart while busy ignored
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,           6'h00, 0, 0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 2, 0, 0,           6'h0F, 0, 0,         0));
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h00, 0, 0,         0));
    // mem stall in the start cycle does not stop the load
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 0,           6'h1F, 0, 0,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h0F, 0, 0,         1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h00, 0, 0,         0));
    // flush overrides stalls and drops the pending hold; flush_req in FLUSH is ignored
    vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0,           6'h0F, 0, 0,         0));
    vecs.push_back(mk(0, 1, 1, 0, 0, 1, H,           6'h00, 1, H,         1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 32'h12345678, 6'h00, 0, H,        0));
    vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,           6'h07, 0, H,         0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,           6'h00, 0, H,         0));

    foreach (vecs[i]) begin
      drive(vecs[i].ifr, vecs[i].idr, vecs[i].memr, vecs[i].exs, vecs[i].k, vecs[i].fr, vecs[i].pc);
      @(negedge clock);
      check($sformatf("vec%0d_stall", i), {26'b0, stall}, {26'b0, vecs[i].e_stall});
      check($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].e_flush});
      check($sformatf("vec%0d_new_pc", i), new_pc, vecs[i].e_pc);
      check($sformatf("vec%0d_busy", i), {31'b0, ex_hold_busy}, {31'b0, vecs[i].e_busy});
      next_cycle();
    end
    drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
    check("wdog_before", {31'b0, wdog_timeout}, 32'h0);

    // watchdog: 1023 stalled cycles not enough, the 1024th sets it
    drive(0, 0, 1, 0, 6'd0, 0, 32'h0);
    repeat (1023) next_cycle();
    check("wdog_1023", {31'b0, wdog_timeout}, 32'h0);
    next_cycle();
    check("wdog_1024", {31'b0, wdog_timeout}, 32'h1);
    drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
    repeat (5) next_cycle();
    check("wdog_sticky", {31'b0, wdog_timeout}, 32'h1);
    check("wdog_sticky_stall", {26'b0, stall}, 32'h0);

    // reset mid-hold
    drive(0, 0, 0, 1, 6'd5, 0, 32'h0);
    next_cycle();
    drive(0, 0, 0, 0, 6'd0, 0, 32'h0);
    check("hold5_busy", {31'b0, ex_hold_busy}, 32'h1);
    check("hold5_stall", {26'b0, stall}, 32'h0F);
    reset = 1'b1;
    next_cycle();
    check("rst_hold_busy", {31'b0, ex_hold_busy}, 32'h0);
    check("rst_hold_stall", {26'b0, stall}, 32'h0);
    check("rst_wdog", {31'b0, wdog_timeout}, 32'h0);
    check("rst_new_pc", new_pc, 32'h0);
    reset = 1'b0;
    next_cycle();
    check("post_rst_busy", {31'b0, ex_hold_busy}, 32'h0);
    check("post_rst_stall", {26'b0, stall}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
